// File: rtl/pio_subsystem.sv
// rtl/pio_subsystem.sv - NUM_CORES pio_core instances routed onto NUM_GPIO pads with config bus,
// input synchronisers, pull controls and break-before-make on core reselection.

module pio_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_gpio_input,
  output logic [31:0] o_gpio_output,
  output logic [31:0] o_gpio_drive
);
  logic [31:0] r_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sample <= '0;
    else     r_sample <= i_gpio_input;
  end

  // Unprogrammed core: echoes its inputs but never takes a pad.
  assign o_gpio_output = r_sample;
  assign o_gpio_drive  = '0;
endmodule

module pio_subsystem #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_GPIO     = 32,
  parameter int BREAK_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic                cfg_write,
  input  logic [5:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
  output logic [31:0]         cfg_rdata,
  output logic                cfg_rvalid,
  output logic                cfg_err,
  output logic [NUM_GPIO-1:0] pad_pde,
  output logic [NUM_GPIO-1:0] pad_pue,
  inout  wire  [NUM_GPIO-1:0] gpio
);
  localparam int NUM_SEL_WORDS = (NUM_GPIO + 7) / 8;

  logic [NUM_GPIO-1:0]   r_bypass, r_pde, r_pue, r_oe, r_out, r_sync1, r_sync2;
  logic [NUM_CORES-1:0]  r_core_en;
  logic [4*NUM_GPIO-1:0] r_sel;
  logic [3:0]            r_brk [NUM_GPIO];
  logic                  r_run, r_rvalid, r_err;
  logic [31:0]           r_rdata;

  logic [NUM_CORES*32-1:0] w_core_out, w_core_drv;
  logic [511:0]            w_out_pad, w_drv_pad;
  logic [15:0]             w_en_pad;
  logic [127:0]            w_sel_pad;
  logic [31:0]             w_in_data, w_rd_val;
  logic [NUM_GPIO-1:0]     w_sel_hit, w_sel_chg, w_oe_nxt, w_out_nxt;
  logic                    w_accept, w_mapped, w_brk_busy;

  always_comb begin
    w_brk_busy = 1'b0;
    for (int p = 0; p < NUM_GPIO; p++)
      if (r_brk[p] != 4'd0) w_brk_busy = 1'b1;
  end

  assign cfg_ready  = r_run & ~w_brk_busy;
  assign w_accept   = cfg_valid & cfg_ready;
  assign w_mapped   = cfg_addr < 6'(4 + NUM_SEL_WORDS);
  assign cfg_rdata  = r_rdata;
  assign cfg_rvalid = r_rvalid;
  assign cfg_err    = r_err;
  assign pad_pde    = r_pde;
  assign pad_pue    = r_pue;

  always_comb begin
    w_sel_pad = '0;
    w_sel_pad[4*NUM_GPIO-1:0] = r_sel;
    w_rd_val = '0;
    case (cfg_addr)
      6'd0: w_rd_val[NUM_GPIO-1:0]  = r_bypass;
      6'd1: w_rd_val[NUM_GPIO-1:0]  = r_pde;
      6'd2: w_rd_val[NUM_GPIO-1:0]  = r_pue;
      6'd3: w_rd_val[NUM_CORES-1:0] = r_core_en;
      default: if (w_mapped) w_rd_val = w_sel_pad[32*cfg_addr[1:0] +: 32];
    endcase
  end

  always_comb begin
    for (int p = 0; p < NUM_GPIO; p++) begin
      w_sel_hit[p] = w_accept & cfg_write & (cfg_addr == 6'(4 + p / 8));
      w_sel_chg[p] = w_sel_hit[p] & (cfg_wdata[4*(p%8) +: 4] != r_sel[4*p +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_bypass  <= '0;
      r_pde     <= '0;
      r_pue     <= '0;
      r_core_en <= '0;
      r_sel     <= '0;
    end else begin
      r_run    <= 1'b1;
      r_rvalid <= w_accept & ~cfg_write;
      r_err    <= w_accept & ~w_mapped;
      if (w_accept & ~cfg_write) r_rdata <= w_rd_val;
      if (w_accept & cfg_write) begin
        case (cfg_addr)
          6'd0: r_bypass  <= cfg_wdata[NUM_GPIO-1:0];
          6'd1: r_pde     <= cfg_wdata[NUM_GPIO-1:0];
          6'd2: r_pue     <= cfg_wdata[NUM_GPIO-1:0];
          6'd3: r_core_en <= cfg_wdata[NUM_CORES-1:0];
          default: ;
        endcase
      end
      for (int p = 0; p < NUM_GPIO; p++)
        if (w_sel_hit[p]) r_sel[4*p +: 4] <= cfg_wdata[4*(p%8) +: 4];
    end
  end

  // A changed selection parks the pin for BREAK_CYCLES before the new core may drive it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_GPIO; p++) r_brk[p] <= 4'd0;
    end else begin
      for (int p = 0; p < NUM_GPIO; p++) begin
        if (w_sel_chg[p])          r_brk[p] <= 4'(BREAK_CYCLES);
        else if (r_brk[p] != 4'd0) r_brk[p] <= r_brk[p] - 4'd1;
      end
    end
  end

  always_comb begin
    w_out_pad = '0;
    w_drv_pad = '0;
    w_en_pad  = '0;
    w_out_pad[NUM_CORES*32-1:0] = w_core_out;
    w_drv_pad[NUM_CORES*32-1:0] = w_core_drv;
    w_en_pad[NUM_CORES-1:0]     = r_core_en;
  end

  always_comb begin
    for (int p = 0; p < NUM_GPIO; p++) begin
      w_oe_nxt[p]  = 1'b0;
      w_out_nxt[p] = 1'b0;
      if (int'(r_sel[4*p +: 4]) < NUM_CORES) begin
        w_out_nxt[p] = w_out_pad[32*int'(r_sel[4*p +: 4]) + p];
        w_oe_nxt[p]  = w_en_pad[r_sel[4*p +: 4]] & w_drv_pad[32*int'(r_sel[4*p +: 4]) + p] &
                       (r_brk[p] == 4'd0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oe    <= '0;
      r_out   <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_oe    <= w_oe_nxt;
      r_out   <= w_out_nxt;
      r_sync1 <= gpio;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_in_data = '0;
    w_in_data[NUM_GPIO-1:0] = (r_bypass & r_sync1) | (~r_bypass & r_sync2);
  end

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_pad
    assign gpio[g] = r_oe[g] ? r_out[g] : 1'bz;
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    pio_core u_core (
      .clk          (clk),
      .rst          (rst),
      .i_gpio_input (w_in_data),
      .o_gpio_output(w_core_out[32*c +: 32]),
      .o_gpio_drive (w_core_drv[32*c +: 32])
    );
  end
endmodule

// File: tb/tb_pio_subsystem.sv
// tb/tb_pio_subsystem.sv - table, directed and randomized checks of pio_subsystem against a register-level model.
module tb_pio_subsystem;
  localparam int NC  = 4;
  localparam int NG  = 32;
  localparam int BC  = 2;
  localparam int NSW = (NG + 7) / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic cfg_valid, cfg_write, cfg_ready, cfg_rvalid, cfg_err;
  logic [5:0] cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic [NG-1:0] pad_pde, pad_pue;
  wire  [NG-1:0] gpio;
  logic ext_oe, ext_val;
  logic [NC*32-1:0] core_out, core_drv;

  assign gpio[5] = ext_oe ? ext_val : 1'bz;

  pio_subsystem #(.NUM_CORES(NC), .NUM_GPIO(NG), .BREAK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_write(cfg_write), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid), .cfg_err(cfg_err),
    .pad_pde(pad_pde), .pad_pue(pad_pue), .gpio(gpio)
  );

  int m_sel [NG];
  int m_cnt [NG];
  logic [31:0] m_byp, m_pde, m_pue, m_en, m_oe, m_out, m_rdata;
  bit m_run, m_rvalid, m_err, acc_flag;
  int n_vec = 0, n_bad = 0;

  typedef struct {
    bit          wr;
    int          addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          err;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    bit r = m_run;
    for (int p = 0; p < NG; p++) if (m_cnt[p] != 0) r = 0;
    return r;
  endfunction

  function automatic logic [31:0] m_read(int a);
    logic [31:0] r = '0;
    case (a)
      0: r = m_byp;
      1: r = m_pde;
      2: r = m_pue;
      3: r = m_en;
      default:
        if (a >= 4 && a < 4 + NSW)
          for (int k = 0; k < 8; k++)
            if (8 * (a - 4) + k < NG) r[4*k +: 4] = 4'(m_sel[8 * (a - 4) + k]);
    endcase
    return r;
  endfunction

  task automatic m_reset();
    for (int p = 0; p < NG; p++) begin m_sel[p] = 0; m_cnt[p] = 0; end
    m_byp = '0; m_pde = '0; m_pue = '0; m_en = '0; m_oe = '0; m_out = '0;
    m_rdata = '0; m_run = 0; m_rvalid = 0; m_err = 0; acc_flag = 0;
  endtask

  task automatic model_step();
    logic [31:0] noe, nout;
    bit rdy;
    int a;
    rdy = m_ready();
    a = int'(cfg_addr);
    noe = '0; nout = '0;
    for (int p = 0; p < NG; p++)
      if (m_sel[p] < NC) begin
        nout[p] = core_out[32 * m_sel[p] + p];
        noe[p]  = m_en[m_sel[p]] && core_drv[32 * m_sel[p] + p] && m_cnt[p] == 0;
      end
    acc_flag = cfg_valid && rdy;
    m_rvalid = acc_flag && !cfg_write;
    m_err    = acc_flag && !(a < 4 + NSW);
    if (acc_flag && !cfg_write) m_rdata = m_read(a);
    for (int p = 0; p < NG; p++) if (m_cnt[p] > 0) m_cnt[p]--;
    if (acc_flag && cfg_write) begin
      case (a)
        0: m_byp = cfg_wdata;
        1: m_pde = cfg_wdata;
        2: m_pue = cfg_wdata;
        3: m_en  = cfg_wdata & ((32'd1 << NC) - 1);
        default:
          if (a < 4 + NSW)
            for (int k = 0; k < 8; k++)
              if (8 * (a - 4) + k < NG && int'(cfg_wdata[4*k +: 4]) != m_sel[8 * (a - 4) + k]) begin
                m_sel[8 * (a - 4) + k] = int'(cfg_wdata[4*k +: 4]);
                m_cnt[8 * (a - 4) + k] = BC;
              end
      endcase
    end
    m_run = 1; m_oe = noe; m_out = nout;
  endtask

  task automatic check_all();
    chk("ready", cfg_ready, m_ready());
    chk("pad_oe", dut.r_oe, m_oe);
    chk("pad_val", gpio & m_oe, m_out & m_oe);
    chk("rvalid", cfg_rvalid, m_rvalid);
    chk("err", cfg_err, m_err);
    chk("rdata", cfg_rdata, m_rdata);
    chk("pde", pad_pde, m_pde);
    chk("pue", pad_pue, m_pue);
  endtask

  task automatic tick();
    @(posedge clk);
    acc_flag = 0;
    if (!rst) model_step();
    #1 check_all();
  endtask

  task automatic cfg(input bit wr, input int a, input logic [31:0] d);
    int k = 0;
    cfg_valid = 1; cfg_write = wr; cfg_addr = 6'(a); cfg_wdata = d;
    do begin tick(); k++; end while (!acc_flag && k < 60);
    if (!acc_flag) chk("cfg_accept_timeout", 32'(k), 32'd0);
    cfg_valid = 0;
  endtask

  initial begin
    force dut.w_core_out = core_out;
    force dut.w_core_drv = core_drv;
    rst = 1; cfg_valid = 0; cfg_write = 0; cfg_addr = '0; cfg_wdata = '0;
    ext_oe = 0; ext_val = 0; core_out = '0; core_drv = '0;
    m_reset();
    tbl[0]  = '{1'b1, 1,  32'hA5A50F0F, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 1,  32'h0,        32'hA5A50F0F, 1'b0};
    tbl[2]  = '{1'b1, 2,  32'h12345678, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 2,  32'h0,        32'h12345678, 1'b0};
    tbl[4]  = '{1'b1, 3,  32'hFFFFFFFF, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 3,  32'h0,        32'h0000000F, 1'b0};
    tbl[6]  = '{1'b1, 5,  32'h76543210, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 5,  32'h0,        32'h76543210, 1'b0};
    tbl[8]  = '{1'b0, 8,  32'h0,        32'h0,        1'b1};
    tbl[9]  = '{1'b1, 63, 32'hDEADBEEF, 32'h0,        1'b1};
    tbl[10] = '{1'b0, 1,  32'h0,        32'hA5A50F0F, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 0;
    tick();
    chk("ready_after_release", cfg_ready, 1'b1);

    cfg(0, 3, 0);
    chk("reset_core_en_rvalid", cfg_rvalid, 1'b1);
    chk("reset_core_en_rdata", cfg_rdata, 32'h0);
    chk("reset_all_hiz", dut.r_oe, 32'h0);

    for (int i = 0; i < 11; i++) begin
      cfg(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].err);
      chk($sformatf("tbl%0d_rvalid", i), cfg_rvalid, !tbl[i].wr);
      if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), cfg_rdata, tbl[i].rd);
    end

    cfg(1, 3, 0);
    tick();
    core_drv[3] = 1; core_out[3] = 1;
    cfg(1, 3, 1);
    tick();
    chk("en_pin3_oe", dut.r_oe[3], 1'b1);
    chk("en_pin3_val", gpio[3], 1'b1);
    cfg(1, 3, 0);
    tick();
    chk("dis_pin3_hiz", dut.r_oe[3], 1'b0);

    core_drv = '0; core_out = '0;
    core_drv[0] = 1; core_out[0] = 1; core_drv[32] = 1; core_out[32] = 0;
    cfg(1, 3, 3);
    tick(); tick();
    chk("brk_pre_val", gpio[0], 1'b1);
    cfg(1, 4, 1);
    chk("brk_ready0", cfg_ready, 1'b0);
    tick();
    chk("brk_hiz1", dut.r_oe[0], 1'b0);
    chk("brk_ready1", cfg_ready, 1'b0);
    tick();
    chk("brk_hiz2", dut.r_oe[0], 1'b0);
    chk("brk_ready2", cfg_ready, 1'b1);
    tick();
    chk("brk_new_oe", dut.r_oe[0], 1'b1);
    chk("brk_new_val", gpio[0], 1'b0);
    cfg(1, 4, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("same_sel_no_gap", dut.r_oe[0], 1'b1);
      chk("same_sel_ready", cfg_ready, 1'b1);
    end

    core_drv = '0;
    ext_oe = 1; ext_val = 0;
    repeat (3) tick();
    ext_val = 1;
    tick();
    chk("sync2_edge1", dut.w_in_data[5], 1'b0);
    tick();
    chk("sync2_edge2", dut.w_in_data[5], 1'b1);
    ext_val = 0;
    repeat (3) tick();
    cfg(1, 0, 32'h20);
    tick();
    chk("byp_idle", dut.w_in_data[5], 1'b0);
    ext_val = 1;
    tick();
    chk("byp_edge1", dut.w_in_data[5], 1'b1);
    ext_oe = 0;
    cfg(1, 0, 0);

    cfg(0, 32, 0);
    chk("unmap_rd_rdata", cfg_rdata, 32'h0);
    chk("unmap_rd_rvalid", cfg_rvalid, 1'b1);
    chk("unmap_rd_err", cfg_err, 1'b1);
    cfg(1, 32, 32'hFFFFFFFF);
    chk("unmap_wr_err", cfg_err, 1'b1);
    for (int a = 0; a < 8; a++) cfg(0, a, 0);

    core_drv[0] = 1; core_drv[64] = 1;
    cfg(1, 3, 32'h7);
    cfg(1, 4, 2);
    cfg_valid = 1; cfg_write = 0; cfg_addr = 6'd3;
    tick();
    #2 rst = 1;
    #1;
    m_reset();
    chk("rst_hiz", dut.r_oe, 32'h0);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_rvalid", cfg_rvalid, 1'b0);
    check_all();
    tick();
    chk("rst_hold_rvalid", cfg_rvalid, 1'b0);
    chk("rst_hold_ready", cfg_ready, 1'b0);
    @(negedge clk);
    rst = 0; cfg_valid = 0;
    tick();
    chk("rst_release_ready", cfg_ready, 1'b1);

    for (int cyc = 0; cyc < 2000; cyc++) begin
      core_out = {$urandom, $urandom, $urandom, $urandom};
      core_drv = {$urandom, $urandom, $urandom, $urandom};
      if (!cfg_valid && $urandom_range(0, 1) == 1) begin
        cfg_valid = 1;
        cfg_write = 1'($urandom_range(0, 1));
        cfg_addr  = ($urandom_range(0, 9) < 7) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
        cfg_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      end
      tick();
      if (acc_flag) cfg_valid = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
